vga_scan_render: RTL

- Produces the 640x480@60 VGA raster that drives the snake game's pixel classification.
- Generates x_pos/y_pos scan coordinates, which the snake logic decodes into a 2-bit pixel class.
- Samples that class plus an apple flag and maps them to 12-bit RGB.
- Emits hsync/vsync aligned with the RGB.
- Sits between the game core (snake, apple logic) and the board VGA connector.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_scan_render_if.sv | 27 ++
 rtl/vga_timing.sv | 82 ++++++++
 rtl/vga_scan_render.sv | 105 ++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the snake-game VGA scan/render path: default 640x480@60
// timing, snake pixel classes, game status codes and the 12-bit palette.
package vga_pkg;

  localparam int unsigned DEF_CLK_DIV  = 2;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    SNAKE_NONE = 2'b00,
    SNAKE_HEAD = 2'b01,
    SNAKE_BODY = 2'b10,
    SNAKE_WALL = 2'b11
  } snake_code_e;

  localparam logic [1:0] GS_RESTART = 2'b00;
  localparam logic [1:0] GS_PLAY    = 2'b10;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t RGB_BLACK  = 12'h000;
  localparam rgb12_t RGB_GREY   = 12'h888;
  localparam rgb12_t RGB_RED    = 12'hF00;
  localparam rgb12_t RGB_YELLOW = 12'hFF0;
  localparam rgb12_t RGB_GREEN  = 12'h0F0;
  localparam rgb12_t RGB_GRID   = 12'h222;

  // Both 01 and 11 mean game over.
  function automatic logic game_over(logic [1:0] gs);
    return (gs != GS_RESTART) && (gs != GS_PLAY);
  endfunction

endpackage

// File: rtl/vga_scan_render_if.sv
// Bundle between the game core (master) and the VGA scan/render block (slave).
interface vga_scan_render_if;

  logic [1:0] snake_code;
  logic       apple_pix;
  logic [1:0] game_status;
  logic       pix_en;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;

  modport slave (
    input  snake_code, apple_pix, game_status,
    output pix_en, x_pos, y_pos, frame_start, hsync, vsync, vga_r, vga_g, vga_b
  );

  modport master (
    output snake_code, apple_pix, game_status,
    input  pix_en, x_pos, y_pos, frame_start, hsync, vsync, vga_r, vga_g, vga_b
  );

endinterface

// File: rtl/vga_timing.sv
// Pixel-clock divider, horizontal/vertical scan counters, frame strobe and the
// unregistered sync/active decode of the current scan position.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en_o,
  output logic [9:0] x_pos_o,
  output logic [9:0] y_pos_o,
  output logic       frame_start_o,
  output logic       hsync_raw_o,
  output logic       vsync_raw_o,
  output logic       active_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             pix_en;

  assign pix_en = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = pix_en ? '0 : div_cnt_q + DIV_W'(1);
    x_d       = x_q;
    y_d       = y_q;
    if (pix_en) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign pix_en_o      = pix_en;
  assign x_pos_o       = x_q;
  assign y_pos_o       = y_q;
  assign frame_start_o = pix_en && (x_q == '0) && (y_q == '0);
  assign hsync_raw_o   = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
  assign vsync_raw_o   = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));
  assign active_o      = (x_q < X_ACT) && (y_q < Y_ACT);

endmodule

// File: rtl/vga_scan_render.sv
// VGA scan + render top: one-pixel render register aligning RGB with syncs.
// Optional VGA_GRID_LINES_EN draws an 8x8 cell grid on empty active pixels.
module vga_scan_render
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input logic               clk,
  input logic               rst,
  vga_scan_render_if.slave  bus
);

  logic       pix_en;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       frame_start;
  logic       hsync_raw;
  logic       vsync_raw;
  logic       active;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .pix_en_o     (pix_en),
    .x_pos_o      (x_pos),
    .y_pos_o      (y_pos),
    .frame_start_o(frame_start),
    .hsync_raw_o  (hsync_raw),
    .vsync_raw_o  (vsync_raw),
    .active_o     (active)
  );

  rgb12_t colour_next;
  rgb12_t rgb_q, rgb_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;

  // Snake class outranks the apple; anything outside the active area is black.
  always_comb begin
    colour_next = RGB_BLACK;
    if (active) begin
      case (bus.snake_code)
        SNAKE_WALL: colour_next = game_over(bus.game_status) ? RGB_RED : RGB_GREY;
        SNAKE_HEAD: colour_next = RGB_YELLOW;
        SNAKE_BODY: colour_next = RGB_GREEN;
        SNAKE_NONE: begin
          if (bus.apple_pix) begin
            colour_next = RGB_RED;
          end
`ifdef VGA_GRID_LINES_EN
          else if ((x_pos[2:0] == 3'd0) || (y_pos[2:0] == 3'd0)) begin
            colour_next = RGB_GRID;
          end
`endif
        end
      endcase
    end
  end

  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_en) begin
      rgb_d   = colour_next;
      hsync_d = hsync_raw;
      vsync_d = vsync_raw;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q   <= RGB_BLACK;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign bus.pix_en      = pix_en;
  assign bus.x_pos       = x_pos;
  assign bus.y_pos       = y_pos;
  assign bus.frame_start = frame_start;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.vga_r       = rgb_q[11:8];
  assign bus.vga_g       = rgb_q[7:4];
  assign bus.vga_b       = rgb_q[3:0];

endmodule
